blink_multi: RTL and testbench
==============================

// Module: blink_multi
// PURPOSE
//  Multi-channel LED blinker; parametrised successor of the single-rate board blinker.
//  One shared free-running prescaler produces a tick strobe.
//  Each channel has its own mode and rate, set through a one-cycle config write port.
//  Drives the active-low board LEDs (LED off = HI).
// PARAMETERS
//  CDIV  24  prescaler width; tick period = 2**CDIV clocks (CDIV >= 1)
//  NCH   3   number of LED channels (1..16)
//  RW    3   rate field width; half-period = rate+1 ticks
// PORTS
//  clk       in   1              system clock, all logic on rising edge
//  n_rst     in   1              reset, synchronous, active-low
//  cfg_we    in   1              config write strobe, one clock per write
//  cfg_ch    in   $clog2(NCH)|1  target channel index
//  cfg_mode  in   2              0 OFF, 1 ON, 2 BLINK, 3 ONESHOT
//  cfg_rate  in   RW             rate value r
//  cfg_duty  in   4              brightness 0..15 (used only with BLINK_PWM_EN)
//  led       out  NCH            LED drive, active-low, registered
//  tick      out  1              prescaler strobe, one clock wide, registered
// BEHAVIOUR
//  - Reset (n_rst=0 at an edge): prescaler=0, tick=0, all channels OFF, phase=0, duty=15, led='1.
//  - Prescaler: free-running, wraps at 2**CDIV-1; tick=1 for the cycle after the wrap.
//    Config writes never reset it.
//  - Write: with cfg_we=1 at an edge, channel cfg_ch loads mode/rate/duty and phase:=0.
//    The led bit reflects the new mode from the next cycle (1-cycle latency).
//    BLINK and ONESHOT start lit.
//  - cfg_ch >= NCH: write ignored; no state changes.
//  - OFF: led=1. ON: led=0. Tick is ignored in both.
//  - BLINK: on each tick, phase++. When phase==rate, phase:=0 and the led toggles.
//    Result: lit r+1 ticks, dark r+1 ticks, repeating.
//  - ONESHOT: lit; on each tick, phase++. When phase==rate, mode:=OFF and led=1 (stays OFF).
//  - Write and tick at the same edge on the same channel: the write wins; that tick is lost.
//    Other channels still consume the tick.
//  - First half-period after a write: between r*2**CDIV+1 and (r+1)*2**CDIV clocks
//    (prescaler phase is arbitrary).
//  - Reset mid-blink or mid-oneshot: channel returns to OFF; the next tick is a full period away.
//  - phase is RW bits wide; rate = 2**RW-1 is legal (phase reaches all-ones, no overflow).
// CONFIGURATION
//  BLINK_PWM_EN defined:
//    - A 4-bit free-running pwm_cnt runs at clk.
//    - A logically lit channel drives led=0 only while pwm_cnt <= duty.
//      duty 15 = full on; duty 0 = 1/16 on.
//    - pwm_cnt resets to 0.
//  BLINK_PWM_EN undefined:
//    - cfg_duty is ignored and no PWM logic is built.
//    - A logically lit channel drives led=0 continuously.
// STRUCTURE
//  blink_pkg:
//    - blink_mode_t enum {MODE_OFF, MODE_ON, MODE_BLINK, MODE_ONESHOT}, 2 bits.
//    - LED_ON=1'b0, LED_OFF=1'b1.
//    - PWM_W=4.
//  blink_chan sub-module (generate, NCH copies):
//    - Holds mode/phase/lit/duty; inputs tick, pwm_cnt, we_sel.
//    - One registered led bit.
//  Top level: prescaler, tick register, optional pwm_cnt, write decode, channel array.
// TESTING (bench: CDIV=2, NCH=3, RW=3; tick every 4 clocks)
//  1 Reset: hold n_rst=0 2 clocks -> led==3'b111, tick==0, prescaler==0.
//    Release -> tick first high 4 clocks later, then every 4 clocks.
//  2 Write ch1 ON, then ch2 OFF -> led==3'b101 the cycle after the write.
//    ch0 and ch2 unaffected by the ch1 write.
//  3 Write ch0 BLINK r=1 -> led[0]=0 next cycle, toggles every 2nd tick (8 clocks).
//    Check over 40 clocks; first toggle 5..8 clocks after the write.
//  4 Write ch2 ONESHOT r=2 -> led[2]=0 for 3 ticks, then 1 and stays 1 for 10 more ticks.
//  5 cfg_ch=3 write -> led and internal state unchanged.
//    Rewrite ch0 BLINK on a tick edge -> phase==0 and led[0]=0 after that edge.
//  6 BLINK_PWM_EN, ch1 ON duty=3 -> led[1]=0 for 4 of every 16 clocks (pwm_cnt 0..3).
//    duty=15 -> led[1]==0 constantly.

Source files
------------

// File: rtl/blink_pkg.sv
// Shared types and constants for the multi-channel LED blinker.
package blink_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_ONESHOT = 2'd3
    } blink_mode_t;

    // Board LEDs are active-low.
    localparam logic LED_ON  = 1'b0;
    localparam logic LED_OFF = 1'b1;

    localparam int PWM_W = 4;

    // Channel-index width; a single channel still needs one select bit.
    function automatic int chan_w(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/blink_multi_if.sv
// One-cycle configuration write port of the multi-channel blinker.
interface blink_multi_if
    import blink_pkg::*;
#(
    parameter int NCH = 3,
    parameter int RW  = 3
);

    localparam int CHW = chan_w(NCH);

    logic             cfg_we;
    logic [CHW-1:0]   cfg_ch;
    blink_mode_t      cfg_mode;
    logic [RW-1:0]    cfg_rate;
    logic [PWM_W-1:0] cfg_duty;

    modport master (
        output cfg_we, cfg_ch, cfg_mode, cfg_rate, cfg_duty
    );

    modport slave (
        input cfg_we, cfg_ch, cfg_mode, cfg_rate, cfg_duty
    );

endinterface

// File: rtl/blink_chan.sv
// One LED channel: mode/phase/lit state machine with a registered active-low LED bit.
// Duty register and PWM gating exist only when BLINK_PWM_EN is defined.
module blink_chan
    import blink_pkg::*;
#(
    parameter int RW = 3
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             tick,
`ifdef BLINK_PWM_EN
    input  logic [PWM_W-1:0] pwm_cnt,
    input  logic [PWM_W-1:0] cfg_duty,
`endif
    input  logic             we_sel,
    input  blink_mode_t      cfg_mode,
    input  logic [RW-1:0]    cfg_rate,
    output logic             led
);

    blink_mode_t   mode, mode_n;
    logic [RW-1:0] rate, rate_n;
    logic [RW-1:0] phase, phase_n;
    logic          lit, lit_n;

    always_comb begin
        // NOTE: every output gets a default before any branch so no latch is inferred.
        mode_n  = mode;
        rate_n  = rate;
        phase_n = phase;
        lit_n   = lit;
        if (we_sel) begin
            // A write on a tick edge wins; this channel loses that tick.
            mode_n  = cfg_mode;
            rate_n  = cfg_rate;
            phase_n = '0;
            lit_n   = (cfg_mode != MODE_OFF);
        end else if (tick) begin
            unique case (mode)
                MODE_BLINK: begin
                    if (phase == rate) begin
                        phase_n = '0;
                        lit_n   = !lit;
                    end else begin
                        phase_n = phase + 1'b1;
                    end
                end
                MODE_ONESHOT: begin
                    if (phase == rate) begin
                        mode_n  = MODE_OFF;
                        phase_n = '0;
                        lit_n   = 1'b0;
                    end else begin
                        phase_n = phase + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BLINK_PWM_EN
    logic [PWM_W-1:0] duty, duty_n;

    assign duty_n = we_sel ? cfg_duty : duty;

    always_ff @(posedge clk) begin
        if (!n_rst) duty <= '1;
        else        duty <= duty_n;
    end
`endif

    // led is computed from next-state so a write shows on the LED one cycle later.
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (!n_rst) begin
            mode  <= MODE_OFF;
            rate  <= '0;
            phase <= '0;
            lit   <= 1'b0;
            led   <= LED_OFF;
        end else begin
            mode  <= mode_n;
            rate  <= rate_n;
            phase <= phase_n;
            lit   <= lit_n;
`ifdef BLINK_PWM_EN
            led   <= (lit_n && (pwm_cnt <= duty_n)) ? LED_ON : LED_OFF;
`else
            led   <= lit_n ? LED_ON : LED_OFF;
`endif
        end
    end

endmodule

// File: rtl/blink_multi.sv
// Multi-channel LED blinker top: shared prescaler/tick, write decode, channel array.
// Optional brightness PWM is built only when BLINK_PWM_EN is defined.
module blink_multi
    import blink_pkg::*;
#(
    parameter int CDIV = 24,
    parameter int NCH  = 3,
    parameter int RW   = 3
) (
    input  logic            clk,
    input  logic            n_rst,
    blink_multi_if.slave    cfg,
    output logic [NCH-1:0]  led,
    output logic            tick
);

    localparam int CHW = chan_w(NCH);

    logic [CDIV-1:0] presc;

    // Free-running; config writes never touch it, so tick phase is arbitrary to a writer.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            presc <= '0;
            tick  <= 1'b0;
        end else begin
            presc <= presc + 1'b1;
            tick  <= (presc == '1);
        end
    end

`ifdef BLINK_PWM_EN
    logic [PWM_W-1:0] pwm_cnt;

    always_ff @(posedge clk) begin
        if (!n_rst) pwm_cnt <= '0;
        else        pwm_cnt <= pwm_cnt + 1'b1;
    end
`endif

    // Out-of-range channel indices match no decoder and are silently dropped.
    for (genvar i = 0; i < NCH; i++) begin : gen_chan
        logic we_sel;

        assign we_sel = cfg.cfg_we && (cfg.cfg_ch == CHW'(i));

        blink_chan #(
            .RW(RW)
        ) u_chan (
`ifdef BLINK_PWM_EN
            .pwm_cnt  (pwm_cnt),
            .cfg_duty (cfg.cfg_duty),
`endif
            .clk      (clk),
            .n_rst    (n_rst),
            .tick     (tick),
            .we_sel   (we_sel),
            .cfg_mode (cfg.cfg_mode),
            .cfg_rate (cfg.cfg_rate),
            .led      (led[i])
        );
    end

endmodule

// File: tb/tb_blink_multi.sv
// Directed self-checking bench for blink_multi (CDIV=2, NCH=3, RW=3: tick every 4 clocks).
// Covers the BLINK_PWM_EN build as well when that macro is defined.
module tb_blink_multi;
    import blink_pkg::*;

    localparam int CDIV = 2;
    localparam int NCH  = 3;
    localparam int RW   = 3;
    localparam int CHW  = chan_w(NCH);

    logic           clk = 1'b0;
    logic           n_rst;
    logic [NCH-1:0] led;
    logic           tick;

    blink_multi_if #(.NCH(NCH), .RW(RW)) cfg_bus ();

    blink_multi #(
        .CDIV(CDIV),
        .NCH (NCH),
        .RW  (RW)
    ) dut (
        .clk  (clk),
        .n_rst(n_rst),
        .cfg  (cfg_bus.slave),
        .led  (led),
        .tick (tick)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Advance one clock and settle past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [CHW-1:0] ch, input blink_mode_t mode,
                             input logic [RW-1:0] rate, input logic [PWM_W-1:0] duty);
        cfg_bus.cfg_we   = 1'b1;
        cfg_bus.cfg_ch   = ch;
        cfg_bus.cfg_mode = mode;
        cfg_bus.cfg_rate = rate;
        cfg_bus.cfg_duty = duty;
        step();
        cfg_bus.cfg_we   = 1'b0;
    endtask

    task automatic steps_to_tick(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (tick !== 1'b1 && n < 16);
    endtask

    task automatic wait_tick_low();
        int guard = 0;
        while (tick !== 1'b0 && guard < 8) begin
            step();
            guard++;
        end
    endtask

    int          n;
    int          ticks;
    int          lit_cnt;
    logic        exp_bit;
    logic        os_lit;
    int          os_ph;
    logic        t_pre;
    logic [2:0]  led_s;
    logic [31:0] presc_s;
    logic [31:0] m0_s, ph0_s, m1_s, m2_s;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst            = 1'b0;
        cfg_bus.cfg_we   = 1'b0;
        cfg_bus.cfg_ch   = '0;
        cfg_bus.cfg_mode = MODE_OFF;
        cfg_bus.cfg_rate = '0;
        cfg_bus.cfg_duty = '0;

        // Reset state
        step();
        step();
        check("rst_led", led, 3'b111);
        check("rst_tick", tick, 1'b0);
        check("rst_presc", dut.presc, 0);
        n_rst = 1'b1;

        // Tick cadence after release
        steps_to_tick(n);
        check("tick_first", n, 4);
        for (int j = 1; j <= 8; j++) begin
            step();
            check("tick_period", tick, (j % 4 == 0));
        end

        // ON / OFF writes
        cfg_write(1, MODE_ON, 0, 15);
        check("wr_ch1_on", led, 3'b101);
        cfg_write(2, MODE_OFF, 0, 15);
        check("wr_ch2_off", led, 3'b101);

        // BLINK r=1: lit 2 ticks, dark 2 ticks
        cfg_write(0, MODE_BLINK, 1, 15);
        check("blink_start", led[0], 1'b0);
        check("blink_others", led[2:1], 2'b10);
        n = 0;
        do begin
            step();
            n++;
        end while (led[0] === 1'b0 && n < 12);
        check("blink_first_toggle_5to8", (n >= 5 && n <= 8), 1'b1);
        exp_bit = 1'b1;
        for (int j = 1; j <= 32; j++) begin
            step();
            if (j % 8 == 0) exp_bit = !exp_bit;
            check("blink_period", led[0], exp_bit);
        end

        // ONESHOT r=2: lit 3 ticks, then dark for 10 more
        cfg_write(2, MODE_ONESHOT, 2, 15);
        check("oneshot_start", led[2], 1'b0);
        os_lit = 1'b1;
        os_ph  = 0;
        ticks  = 0;
        n      = 0;
        while (ticks < 13 && n < 100) begin
            t_pre = tick;
            step();
            n++;
            if (t_pre) begin
                ticks++;
                if (os_lit) begin
                    if (os_ph == 2) os_lit = 1'b0;
                    else            os_ph++;
                end
            end
            check("oneshot_led", led[2], !os_lit);
        end
        check("oneshot_ticks_seen", ticks, 13);
        check("oneshot_mode_off", dut.gen_chan[2].u_chan.mode, MODE_OFF);

        // Out-of-range channel write leaves everything alone
        wait_tick_low();
        led_s   = led;
        presc_s = 32'(dut.presc);
        m0_s    = 32'(dut.gen_chan[0].u_chan.mode);
        ph0_s   = 32'(dut.gen_chan[0].u_chan.phase);
        m1_s    = 32'(dut.gen_chan[1].u_chan.mode);
        m2_s    = 32'(dut.gen_chan[2].u_chan.mode);
        cfg_write(3, MODE_ON, 5, 0);
        check("badch_led", led, led_s);
        check("badch_presc", dut.presc, (presc_s + 1) & 32'h3);
        check("badch_mode0", dut.gen_chan[0].u_chan.mode, m0_s);
        check("badch_phase0", dut.gen_chan[0].u_chan.phase, ph0_s);
        check("badch_rate0", dut.gen_chan[0].u_chan.rate, 1);
        check("badch_mode1", dut.gen_chan[1].u_chan.mode, m1_s);
        check("badch_mode2", dut.gen_chan[2].u_chan.mode, m2_s);

        // ch2 BLINK at max rate, then ch0 rewrite on a tick edge
        wait_tick_low();
        cfg_write(2, MODE_BLINK, 7, 15);
        check("maxrate_start", led[2], 1'b0);
        n = 0;
        while (tick !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        check("tick_before_rewrite", tick, 1'b1);
        cfg_write(0, MODE_BLINK, 3, 15);
        check("rewrite_phase0", dut.gen_chan[0].u_chan.phase, 0);
        check("rewrite_led0", led[0], 1'b0);
        check("rewrite_other_phase2", dut.gen_chan[2].u_chan.phase, 1);
        ticks = 1;
        n     = 0;
        while (led[2] === 1'b0 && n < 80) begin
            t_pre = tick;
            step();
            n++;
            if (t_pre) ticks++;
        end
        check("maxrate_lit_ticks", ticks, 8);
        check("maxrate_phase_wrap", dut.gen_chan[2].u_chan.phase, 0);

        // Brightness: PWM gating only in the BLINK_PWM_EN build
        cfg_write(1, MODE_ON, 0, 3);
        lit_cnt = 0;
        for (int j = 0; j < 16; j++) begin
            if (led[1] === LED_ON) lit_cnt++;
            step();
        end
`ifdef BLINK_PWM_EN
        check("pwm_duty3", lit_cnt, 4);
`else
        check("duty_ignored", lit_cnt, 16);
`endif
        cfg_write(1, MODE_ON, 0, 15);
        lit_cnt = 0;
        for (int j = 0; j < 16; j++) begin
            if (led[1] === LED_ON) lit_cnt++;
            step();
        end
        check("duty15_full", lit_cnt, 16);

        // Reset in the middle of blinking
        n_rst = 1'b0;
        step();
        check("midrst_led", led, 3'b111);
        check("midrst_tick", tick, 1'b0);
        check("midrst_presc", dut.presc, 0);
        check("midrst_mode0", dut.gen_chan[0].u_chan.mode, MODE_OFF);
        check("midrst_phase0", dut.gen_chan[0].u_chan.phase, 0);
        n_rst = 1'b1;
        steps_to_tick(n);
        check("midrst_tick_first", n, 4);
        check("midrst_led_stays", led, 3'b111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
